// File: rtl/ring_sequence_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : ring_sequence_decoder_if
//  Brief    : Sample/status bundle between a ring-counter observer and the
//             ring_sequence_decoder phase decoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface ring_sequence_decoder_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  ring_in;
  logic          err_clr;
  logic [IW-1:0] idx;
  logic          valid;
  logic          locked;
  logic          err;
  logic [7:0]    err_cnt;

  // Driver side: supplies samples, observes decoder status
  modport master (
    output ring_in, err_clr,
    input  idx, valid, locked, err, err_cnt
  );

  // Decoder side
  modport slave (
    input  ring_in, err_clr,
    output idx, valid, locked, err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ring_sequence_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ring_sequence_decoder
//  Brief    : Decodes a rotating one-hot ring pattern to a binary phase index,
//             locks onto the rotation sequence and flags bad samples.
//             Optional macro RING_RESYNC_EN: while locked, a valid but
//             mismatching sample realigns the flywheel to the observed phase.
//  Revision : 1.0 - initial release
// ============================================================================
module ring_sequence_decoder #(
  parameter int N          = 4,
  parameter int DIR        = 0,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  ring_sequence_decoder_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_exp, w_exp_nxt;
  logic [MW-1:0] r_match_cnt, w_match_nxt;
  logic [UW-1:0] r_miss_cnt, w_miss_nxt;
  logic          w_err;

  logic [N-1:0]  w_sample;
  logic          w_onehot;
  logic [IW-1:0] w_pos;

  logic [IW-1:0] r_idx;
  logic          r_valid;
  logic          r_locked;
  logic          r_err;
  logic [7:0]    r_err_cnt;

  assign w_sample = bus.ring_in;

  // One step of rotation in the configured direction, with wrap-around
  function automatic logic [N-1:0] rot(input logic [N-1:0] x);
    if (DIR == 0) return {x[N-2:0], x[N-1]};
    else          return {x[0], x[N-1:1]};
  endfunction

  // Classify the sample (exactly one bit set) and locate its set bit
  always_comb begin
    w_pos    = '0;
    w_onehot = (w_sample != '0) && ((w_sample & (w_sample - N'(1))) == '0);
    for (int i = 0; i < N; i++) begin
      if (w_sample[i]) w_pos = IW'(i);
    end
  end

  // Sequence tracker: next state, expected pattern, run counters, error strobe
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err       = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_onehot) begin
          w_exp_nxt   = rot(w_sample);
          w_match_nxt = MW'(1);
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!w_onehot) begin
          w_state_nxt = ST_HUNT;
        end else if (w_sample == r_exp) begin
          w_match_nxt = r_match_cnt + MW'(1);
          w_exp_nxt   = rot(w_sample);
          if (int'(r_match_cnt) + 1 == LOCK_CNT) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = '0;
          end
        end else begin
          // Valid but out of sequence: restart the run from this sample
          w_match_nxt = MW'(1);
          w_exp_nxt   = rot(w_sample);
        end
      end
      ST_LOCKED: begin
        // Flywheel keeps advancing regardless of what was observed
        w_exp_nxt = rot(r_exp);
        if (w_sample == r_exp) begin
          w_miss_nxt = '0;
        end else begin
          w_err      = 1'b1;
          w_miss_nxt = r_miss_cnt + UW'(1);
`ifdef RING_RESYNC_EN
          if (w_onehot) w_exp_nxt = rot(w_sample);
`endif
          if (int'(r_miss_cnt) + 1 == UNLOCK_CNT) w_state_nxt = ST_HUNT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // Tracker state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_exp       <= w_exp_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
    end
  end

  // Registered outputs; idx holds its last good value across bad samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_valid  <= w_onehot;
      if (w_onehot) r_idx <= w_pos;
      r_err    <= w_err;
      r_locked <= (w_state_nxt == ST_LOCKED);
      if (bus.err_clr)                      r_err_cnt <= '0;
      else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.idx     = r_idx;
  assign bus.valid   = r_valid;
  assign bus.locked  = r_locked;
  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/ring_sequence_decoder.md
Name: ring_sequence_decoder

Overview:
Receive-side companion to the 4-bit one-hot ring counter. Samples the rotating one-hot pattern and decodes it to a binary phase index. Locks onto the rotation sequence and flags out-of-sequence or malformed patterns. Sits downstream of a ring counter as a phase decoder and integrity monitor.

Parameters:
N, 4, ring width in bits; must be at least 2.
DIR, 0, expected rotation direction. 0 = left (0001->0010->0100->1000->0001). 1 = right.
LOCK_CNT, 3, consecutive in-sequence valid samples required to lock; must be at least 2.
UNLOCK_CNT, 2, consecutive bad samples while locked that force loss of lock; must be at least 1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
ring_in  input  N  ring counter output; one new value sampled per clk
err_clr  input  1  synchronous clear of err_cnt
idx  output  $clog2(N)  binary position of the set bit in the last sample
valid  output  1  last sample was exactly one-hot
locked  output  1  high while the FSM is in LOCKED
err  output  1  one-cycle pulse per bad sample while LOCKED
err_cnt  output  8  saturating count of err pulses

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-high (rst). On rst, all outputs go to 0, the FSM goes to HUNT, and the internal registers (expected pattern exp, match_cnt, miss_cnt) clear to 0. Reset mid-stream takes effect immediately, with no wait for an edge.
- All outputs are registered. Every value reflects ring_in as sampled at the most recent rising edge (1-cycle latency).
- valid: 1 iff the sample has exactly one bit set. 0000 and multi-hot samples give valid=0.
- idx: bit position of the set bit when valid=1. It holds its previous value when valid=0.
- rot(x): rotate by one position in DIR, with wrap-around (MSB->LSB for left, LSB->MSB for right).
- FSM, evaluated at each rising edge:
  - HUNT:
    - valid sample -> exp<=rot(sample), match_cnt<=1, go to CHECK.
    - invalid sample -> stay in HUNT.
    - err never asserts in HUNT.
  - CHECK:
    - sample==exp -> match_cnt+1 and exp<=rot(sample). If match_cnt+1==LOCK_CNT, go to LOCKED and set miss_cnt<=0.
    - valid sample but sample!=exp -> match_cnt<=1, exp<=rot(sample), stay in CHECK.
    - invalid sample -> go to HUNT.
  - LOCKED:
    - exp<=rot(exp) on every edge (flywheel), except where RING_RESYNC_EN overrides.
    - sample==exp -> miss_cnt<=0.
    - sample!=exp (including invalid) -> err=1 for that cycle and miss_cnt+1. If miss_cnt+1==UNLOCK_CNT, go to HUNT; locked falls on the same edge.
- err_cnt: increments on each err pulse and saturates at 255. If err_clr and err occur in the same cycle, clear wins and err_cnt=0.
- locked: registered copy of (next state == LOCKED). It rises on the edge that accepts the LOCK_CNT-th matching sample.

Optional Feature:
RING_RESYNC_EN
- Defined: in LOCKED, a valid sample that mismatches still pulses err and counts toward miss_cnt, but exp<=rot(sample). The flywheel realigns to the observed phase. A single phase jump therefore costs one error, not UNLOCK_CNT errors.
- Undefined: exp always advances from exp while LOCKED, as described in Behaviour.

Test Plan:
All scenarios use N=4, DIR=0, LOCK_CNT=3, UNLOCK_CNT=2 unless stated.
- Lock acquisition: rst pulse, then ring_in 0001,0010,0100,1000 on successive edges -> idx 0,1,2,3; valid=1 throughout; locked=1 after the 3rd edge; err never asserts.
- Single glitch while locked: after lock, inject one 0000 in place of 0001, then resume 0010 -> err=1 for one cycle, valid=0 that cycle, err_cnt=1, locked stays 1, next cycle err=0.
- Loss of lock: while locked, drive 0011 for two edges -> err on both, err_cnt=2, locked=0 after the 2nd edge; a following 0001,0010,0100 relocks.
- Phase jump: locked with exp=0100, drive 1000,0001,... -> without macro: err on every edge, locked drops after 2 edges. With RING_RESYNC_EN: one err pulse, locked stays 1.
- Counter edges: force 256 errors (relocking as needed) -> err_cnt holds 255. Assert err_clr in the same cycle as an err -> err_cnt=0.
- Async reset and DIR=1: assert rst between edges while locked -> outputs 0 immediately. Then with DIR=1, drive 1000,0100,0010 -> locked=1, idx 3,2,1.
